// File: rtl/img_rsz_blk_sched_if.sv
// Job request / result return handshake bus between the block scheduler and the Compute Engine.
interface img_rsz_blk_sched_if #(
    parameter int BLK_X_NUM = 4,
    parameter int BLK_Y_NUM = 4,
    parameter int PXL_W     = 8,
    parameter int COLOR_NUM = 3
);
    localparam int XW = (BLK_X_NUM > 1) ? $clog2(BLK_X_NUM) : 1;
    localparam int YW = (BLK_Y_NUM > 1) ? $clog2(BLK_Y_NUM) : 1;

    logic                       ceReqVld;
    logic                       ceReqRdy;
    logic [XW-1:0]              ceReqX;
    logic [YW-1:0]              ceReqY;
    logic                       ceDoneVld;
    logic                       ceDoneRdy;
    logic [XW-1:0]              ceDoneX;
    logic [YW-1:0]              ceDoneY;
    logic [COLOR_NUM*PXL_W-1:0] ceDoneData;

    modport master (
        output ceReqVld, ceReqX, ceReqY, ceDoneRdy,
        input  ceReqRdy, ceDoneVld, ceDoneX, ceDoneY, ceDoneData
    );

    modport slave (
        input  ceReqVld, ceReqX, ceReqY, ceDoneRdy,
        output ceReqRdy, ceDoneVld, ceDoneX, ceDoneY, ceDoneData
    );
endinterface

// File: rtl/img_rsz_blk_sched.sv
// Block scheduler and execution scoreboard for the resized-pixel forwarding path.
// Optional IMG_RSZ_SCHED_PERF_EN adds the stallCnt issue-stall counter output.
module img_rsz_blk_sched #(
    parameter int BLK_X_NUM = 4,
    parameter int BLK_Y_NUM = 4,
    parameter int PXL_W     = 8,
    parameter int COLOR_NUM = 3,
    parameter int MAX_OUTST = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 frameStart,
    img_rsz_blk_sched_if.master                  ce,
    output logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0]  blkIsExec,
    input  logic [BLK_X_NUM-1:0]                 flushBlkXMsk,
    input  logic [BLK_Y_NUM-1:0]                 flushBlkYMsk,
    input  logic                                 flushVld,
    output logic [COLOR_NUM*PXL_W-1:0]           flushRszPxlData,
    output logic                                 busy,
    output logic                                 frameDone
`ifdef IMG_RSZ_SCHED_PERF_EN
    ,
    output logic [15:0]                          stallCnt
`endif
);
    localparam int XW = (BLK_X_NUM > 1) ? $clog2(BLK_X_NUM) : 1;
    localparam int YW = (BLK_Y_NUM > 1) ? $clog2(BLK_Y_NUM) : 1;
    localparam int DW = COLOR_NUM * PXL_W;
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} schedStateT;

    schedStateT state, stateNxt;

    logic [XW-1:0]                              ptrX;
    logic [YW-1:0]                              ptrY;
    logic [OW-1:0]                              outst;
    logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0]        pending;
    logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0]        issueSet;
    logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0]        doneSet;
    logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0]        flushClr;
    logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0][DW-1:0] pxlBuf;
    logic                                       reqFire;
    logic                                       doneFire;
    logic                                       lastBlk;
    logic                                       flushHit;

    assign reqFire  = ce.ceReqVld && ce.ceReqRdy;
    assign doneFire = ce.ceDoneVld && ce.ceDoneRdy;
    assign lastBlk  = (ptrX == XW'(BLK_X_NUM - 1)) && (ptrY == YW'(BLK_Y_NUM - 1));

    assign ce.ceReqX = ptrX;
    assign ce.ceReqY = ptrY;

    // A result is only taken for a block that was issued and whose flag has been consumed.
    assign ce.ceDoneRdy = pending[ce.ceDoneY][ce.ceDoneX] && !blkIsExec[ce.ceDoneY][ce.ceDoneX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        ce.ceReqVld = 1'b0;
        busy        = (state != IDLE);
        frameDone   = 1'b0;
        case (state)
            IDLE: begin
                if (frameStart) begin
                    stateNxt = ISSUE;
                end
            end
            ISSUE: begin
                ce.ceReqVld = (outst < OW'(MAX_OUTST)) && !blkIsExec[ptrY][ptrX] && !pending[ptrY][ptrX];
                if (ce.ceReqVld && ce.ceReqRdy && lastBlk) begin
                    stateNxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((outst == '0) && (blkIsExec == '0)) begin
                    stateNxt = DONE;
                end
            end
            DONE: begin
                frameDone = 1'b1;
                stateNxt  = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        issueSet = '0;
        doneSet  = '0;
        flushClr = '0;
        if (reqFire) begin
            issueSet[ptrY][ptrX] = 1'b1;
        end
        if (doneFire) begin
            doneSet[ce.ceDoneY][ce.ceDoneX] = 1'b1;
        end
        if (flushVld) begin
            for (int y = 0; y < BLK_Y_NUM; y++) begin
                for (int x = 0; x < BLK_X_NUM; x++) begin
                    flushClr[y][x] = flushBlkYMsk[y] & flushBlkXMsk[x];
                end
            end
        end
    end

    // Set is applied after clear so a same-cycle result and flush leaves the flag up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blkIsExec <= '0;
            pending   <= '0;
            pxlBuf    <= '0;
        end else begin
            blkIsExec <= (blkIsExec & ~flushClr) | doneSet;
            pending   <= (pending | issueSet) & ~doneSet;
            if (doneFire) begin
                pxlBuf[ce.ceDoneY][ce.ceDoneX] <= ce.ceDoneData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst <= '0;
        end else if (reqFire && !doneFire) begin
            outst <= outst + 1'b1;
        end else if (!reqFire && doneFire) begin
            outst <= outst - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptrX <= '0;
            ptrY <= '0;
        end else if (reqFire) begin
            if (ptrX == XW'(BLK_X_NUM - 1)) begin
                ptrX <= '0;
                ptrY <= (ptrY == YW'(BLK_Y_NUM - 1)) ? '0 : ptrY + 1'b1;
            end else begin
                ptrX <= ptrX + 1'b1;
            end
        end
    end

    // Lowest-index masked block in Y-major order; the flag state does not gate the data.
    always_comb begin
        flushRszPxlData = '0;
        flushHit        = 1'b0;
        for (int y = 0; y < BLK_Y_NUM; y++) begin
            for (int x = 0; x < BLK_X_NUM; x++) begin
                if (!flushHit && flushBlkYMsk[y] && flushBlkXMsk[x]) begin
                    flushRszPxlData = pxlBuf[y][x];
                    flushHit        = 1'b1;
                end
            end
        end
    end

`ifdef IMG_RSZ_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if ((state == IDLE) && frameStart) begin
            stallCnt <= '0;
        end else if ((state == ISSUE) && !reqFire && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_img_rsz_blk_sched.sv
// Directed self-checking bench for img_rsz_blk_sched on a 4x4 grid with MAX_OUTST=2.
module tb_img_rsz_blk_sched;
    localparam int BX = 4;
    localparam int BY = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  frameStart = 1'b0;
    logic                  flushVld = 1'b0;
    logic [BX-1:0]         flushXMsk = '0;
    logic [BY-1:0]         flushYMsk = '0;
    logic [BY-1:0][BX-1:0] blkIsExec;
    logic [23:0]           flushData;
    logic                  busy;
    logic                  frameDone;
`ifdef IMG_RSZ_SCHED_PERF_EN
    logic [15:0]           stallCnt;
`endif

    int checksRun = 0;
    int checksPassed = 0;
    int issuedCnt;
    int peakOutst;
    int frameDonePulses;

    typedef struct {
        logic [3:0]  xMsk;
        logic [3:0]  yMsk;
        logic        vld;
        logic [23:0] expData;
        logic [15:0] expFlags;
    } flushVecT;

    flushVecT vecs [7];

    img_rsz_blk_sched_if #(.BLK_X_NUM(BX), .BLK_Y_NUM(BY), .PXL_W(8), .COLOR_NUM(3)) ceIf ();

    img_rsz_blk_sched #(
        .BLK_X_NUM(BX), .BLK_Y_NUM(BY), .PXL_W(8), .COLOR_NUM(3), .MAX_OUTST(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frameStart(frameStart),
        .ce(ceIf.master),
        .blkIsExec(blkIsExec),
        .flushBlkXMsk(flushXMsk),
        .flushBlkYMsk(flushYMsk),
        .flushVld(flushVld),
        .flushRszPxlData(flushData),
        .busy(busy),
        .frameDone(frameDone)
`ifdef IMG_RSZ_SCHED_PERF_EN
        ,
        .stallCnt(stallCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pxlOf(input int x, input int y);
        return {8'(160 + y), 8'(80 + x), 8'(y * 4 + x)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksRun++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] xMsk, input logic [3:0] yMsk, input logic vld);
        flushXMsk = xMsk;
        flushYMsk = yMsk;
        flushVld  = vld;
    endtask

    // Runs one frame with a CE model that returns each job two cycles after issue.
    task automatic runFrame(input bit flushPrev, input bit specialRet);
        int qx[$];
        int qy[$];
        int qt[$];
        int issueIdx = 0;
        int outst = 0;
        int cyc = 0;
        int after = 0;
        bit havePrev = 1'b0;
        bit doneSeen = 1'b0;
        bit doneDrv;
        int prevX = 0;
        int prevY = 0;
        logic [23:0] expFlush;
        issuedCnt = 0;
        peakOutst = 0;
        frameDonePulses = 0;
        frameStart = 1'b1;
        ceIf.ceReqRdy = 1'b1;
        ceIf.ceDoneVld = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        frameStart = 1'b0;
        forever begin
            if (cyc >= 200) begin
                checksRun++;
                $display("[TB] FAIL frameTimeout: got %0d issued, expected 16 within 200 cycles", issueIdx);
                break;
            end
            doneDrv = (qx.size() > 0) && (qt[0] <= cyc);
            ceIf.ceDoneVld = doneDrv;
            expFlush = '0;
            applyStimulus(4'h0, 4'h0, 1'b0);
            if (doneDrv) begin
                ceIf.ceDoneX = 2'(qx[0]);
                ceIf.ceDoneY = 2'(qy[0]);
                ceIf.ceDoneData = (specialRet && qx[0] == 2 && qy[0] == 1) ? 24'hA5A5A5 : pxlOf(qx[0], qy[0]);
            end
            if (flushPrev && havePrev) begin
                applyStimulus(4'(1 << prevX), 4'(1 << prevY), 1'b1);
                expFlush = pxlOf(prevX, prevY);
            end
            if (specialRet && doneDrv && qx[0] == 2 && qy[0] == 1) begin
                applyStimulus(4'b0100, 4'b0010, 1'b1);
                expFlush = pxlOf(2, 1);
            end
            #1;
            checkOutput("reqVld", ceIf.ceReqVld, (issueIdx < 16) && (outst < 2));
            if (flushVld) begin
                checkOutput("flushData", flushData, expFlush);
            end
            if (ceIf.ceReqVld) begin
                checkOutput("reqXY", {ceIf.ceReqY, ceIf.ceReqX}, issueIdx);
                qx.push_back(issueIdx % 4);
                qy.push_back(issueIdx / 4);
                qt.push_back(cyc + 2);
                issueIdx++;
                outst++;
            end
            havePrev = 1'b0;
            if (doneDrv) begin
                checkOutput("doneRdy", ceIf.ceDoneRdy, 1);
                if (ceIf.ceDoneRdy) begin
                    prevX = qx.pop_front();
                    prevY = qy.pop_front();
                    void'(qt.pop_front());
                    havePrev = 1'b1;
                    outst--;
                end
            end
            if (outst > peakOutst) peakOutst = outst;
            if (frameDone) begin
                frameDonePulses++;
                doneSeen = 1'b1;
            end else if (doneSeen) begin
                after++;
            end
            @(posedge clk); #1;
            cyc++;
            if (issueIdx == 16 && qx.size() == 0 && (!flushPrev || (doneSeen && after >= 3))) break;
        end
        issuedCnt = issueIdx;
        ceIf.ceDoneVld = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 4'b1111, 1'b0, pxlOf(0, 0), 16'hFFFF};
        vecs[1] = '{4'b1100, 4'b0110, 1'b0, pxlOf(2, 1), 16'hFFFF};
        vecs[2] = '{4'b1000, 4'b1000, 1'b0, pxlOf(3, 3), 16'hFFFF};
        vecs[3] = '{4'b0000, 4'b1111, 1'b1, 24'h000000,  16'hFFFF};
        vecs[4] = '{4'b0010, 4'b0001, 1'b1, pxlOf(1, 0), 16'hFFFD};
        vecs[5] = '{4'b1010, 4'b1100, 1'b0, pxlOf(1, 2), 16'hFFFD};
        vecs[6] = '{4'b0001, 4'b0011, 1'b1, pxlOf(0, 0), 16'hFFEC};

        ceIf.ceReqRdy = 1'b0;
        ceIf.ceDoneVld = 1'b0;
        ceIf.ceDoneX = '0;
        ceIf.ceDoneY = '0;
        ceIf.ceDoneData = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'hF, 4'hF, 1'b0);
        #1;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst reqVld", ceIf.ceReqVld, 0);
        checkOutput("rst frameDone", frameDone, 0);
        checkOutput("rst flags", 32'(blkIsExec), 0);
        checkOutput("rst flushData", flushData, 0);
        checkOutput("rst doneRdy", ceIf.ceDoneRdy, 0);
        applyStimulus(4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;

        $display("[TB] test 1: full frame with one-hot flush of each returned block");
        runFrame(1'b1, 1'b0);
        checkOutput("t1 issued", issuedCnt, 16);
        checkOutput("t1 frameDone pulses", frameDonePulses, 1);
        checkOutput("t1 peak outst", peakOutst, 2);
        checkOutput("t1 busy", busy, 0);

        $display("[TB] test 2: no flush, then flush table and release");
        runFrame(1'b0, 1'b0);
        checkOutput("t2 issued", issuedCnt, 16);
        checkOutput("t2 frameDone pulses", frameDonePulses, 0);
        checkOutput("t2 reqVld idle", ceIf.ceReqVld, 0);
        checkOutput("t2 flags", 32'(blkIsExec), 32'hFFFF);
        checkOutput("t2 busy", busy, 1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].xMsk, vecs[i].yMsk, vecs[i].vld);
            #1;
            checkOutput($sformatf("vec%0d data", i), flushData, vecs[i].expData);
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d flags", i), 32'(blkIsExec), 32'(vecs[i].expFlags));
        end
        applyStimulus(4'hF, 4'hF, 1'b1);
        #1;
        checkOutput("t2 release data", flushData, pxlOf(0, 0));
        @(posedge clk); #1;
        applyStimulus(4'h0, 4'h0, 1'b0);
        checkOutput("t2 flags cleared", 32'(blkIsExec), 0);
        checkOutput("t2 frameDone early", frameDone, 0);
        @(posedge clk); #1;
        checkOutput("t2 frameDone", frameDone, 1);
        @(posedge clk); #1;
        checkOutput("t2 frameDone pulse end", frameDone, 0);
        checkOutput("t2 idle", busy, 0);

        $display("[TB] test 3: result and flush of (2,1) in the same cycle");
        runFrame(1'b0, 1'b1);
        checkOutput("t3 flags set wins", 32'(blkIsExec), 32'hFFFF);
        applyStimulus(4'b0100, 4'b0010, 1'b1);
        #1;
        checkOutput("t3 new data", flushData, 24'hA5A5A5);
        @(posedge clk); #1;
        checkOutput("t3 flag cleared", 32'(blkIsExec), 32'hFFBF);
        applyStimulus(4'hF, 4'hF, 1'b1);
        #1;
        checkOutput("t3 release data", flushData, pxlOf(0, 0));
        @(posedge clk); #1;
        applyStimulus(4'h0, 4'h0, 1'b0);
        checkOutput("t3 flags cleared", 32'(blkIsExec), 0);
        @(posedge clk); #1;
        checkOutput("t3 frameDone", frameDone, 1);
        @(posedge clk); #1;

        $display("[TB] test 4: result for a non-pending block");
        frameStart = 1'b1;
        ceIf.ceReqRdy = 1'b0;
        ceIf.ceDoneVld = 1'b1;
        ceIf.ceDoneX = 2'd3;
        ceIf.ceDoneY = 2'd3;
        ceIf.ceDoneData = 24'h123456;
        #1;
        checkOutput("t4 doneRdy idle", ceIf.ceDoneRdy, 0);
        @(posedge clk); #1;
        frameStart = 1'b0;
        #1;
        checkOutput("t4 doneRdy issue", ceIf.ceDoneRdy, 0);
        checkOutput("t4 first reqVld", ceIf.ceReqVld, 1);
        checkOutput("t4 first reqXY", {ceIf.ceReqY, ceIf.ceReqX}, 0);
        @(posedge clk); #1;
        checkOutput("t4 flags", 32'(blkIsExec), 0);
        ceIf.ceDoneVld = 1'b0;

        $display("[TB] test 5: reset with two jobs outstanding");
        ceIf.ceReqRdy = 1'b1;
        #1;
        checkOutput("t5 reqXY 0", {ceIf.ceReqY, ceIf.ceReqX}, 0);
        @(posedge clk); #1;
        checkOutput("t5 reqXY 1", {ceIf.ceReqY, ceIf.ceReqX}, 1);
        @(posedge clk); #1;
        ceIf.ceReqRdy = 1'b0;
        #1;
        checkOutput("t5 reqVld outst full", ceIf.ceReqVld, 0);
        rst = 1'b1;
        ceIf.ceDoneVld = 1'b1;
        ceIf.ceDoneX = 2'd0;
        ceIf.ceDoneY = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(4'hF, 4'hF, 1'b0);
        #1;
        checkOutput("t5 busy", busy, 0);
        checkOutput("t5 reqVld", ceIf.ceReqVld, 0);
        checkOutput("t5 doneRdy", ceIf.ceDoneRdy, 0);
        checkOutput("t5 frameDone", frameDone, 0);
        checkOutput("t5 flags", 32'(blkIsExec), 0);
        checkOutput("t5 flushData", flushData, 0);
        ceIf.ceDoneVld = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b0);
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        #1;
        checkOutput("t5 reissue vld", ceIf.ceReqVld, 1);
        checkOutput("t5 reissue XY", {ceIf.ceReqY, ceIf.ceReqX}, 0);

        $display("[TB] test 6: request held while the engine stalls");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("t6 reqVld held", ceIf.ceReqVld, 1);
        checkOutput("t6 reqXY held", {ceIf.ceReqY, ceIf.ceReqX}, 0);
`ifdef IMG_RSZ_SCHED_PERF_EN
        checkOutput("t6 stallCnt", stallCnt, 10);
`endif

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end
endmodule
